// File: rtl/vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vend_dispense_ctrl
//  Purpose  : Responder end of the vend FSM output interface. Queues product
//             and change request pulses in saturating counters and drives the
//             spiral motor and the change-hopper solenoid. Each product is
//             confirmed by the drop sensor; a missing drop leads to FAULT.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   clock
//    rst_n       in   asynchronous active-low reset
//    prod_req    in   one-cycle pulse: dispense one product
//    change_req  in   one-cycle pulse: return one change coin
//    drop_sense  in   raw asynchronous drop sensor (high while product falls)
//    fault_clr   in   one-cycle pulse: acknowledge a fault
//    motor_en    out  spiral motor drive
//    change_en   out  hopper solenoid drive
//    busy        out  activity in progress or work pending
//    fault       out  FAULT state indicator
//    ovf         out  sticky: a request was dropped on a full queue
//    pend_prod   out  pending product count
//    pend_chg    out  pending change count
// ============================================================================
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES   = 16,
  parameter int CHG_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int QDEPTH         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prod_req,
  input  logic       change_req,
  input  logic       drop_sense,
  input  logic       fault_clr,
  output logic       motor_en,
  output logic       change_en,
  output logic       busy,
  output logic       fault,
  output logic       ovf,
  output logic [2:0] pend_prod,
  output logic [2:0] pend_chg
);

  // One shared cycle counter serves MOTOR, WAIT_DROP and CHANGE; size it for
  // the longest of the three phases.
  localparam int MAX_MC = (MOTOR_CYCLES > CHG_CYCLES) ? MOTOR_CYCLES : CHG_CYCLES;
  localparam int MAX_ALL = (MAX_MC > TIMEOUT_CYCLES) ? MAX_MC : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] MOTOR_LAST = CW'(MOTOR_CYCLES - 1);
  localparam logic [CW-1:0] CHG_LAST   = CW'(CHG_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    Q_FULL     = 3'(QDEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOTOR     = 3'd1,
    WAIT_DROP = 3'd2,
    CHANGE    = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          drop_seen, drop_seen_nxt;
  logic          dec_prod, dec_chg;

  // --------------------------------------------------------------------------
  // drop_sense: two synchronizer flops, a history flop and a registered
  // rising-edge pulse. A pin edge reaches drop_pulse after three clock edges.
  // --------------------------------------------------------------------------
  logic sync1, sync2, sync3, drop_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      sync1      <= drop_sense;
      sync2      <= sync1;
      sync3      <= sync2;
      drop_pulse <= sync2 & ~sync3;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      drop_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      drop_seen <= drop_seen_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    drop_seen_nxt = drop_seen;
    dec_prod      = 1'b0;
    dec_chg       = 1'b0;
    case (state)
      IDLE: begin
        // Products win arbitration over change coins.
        if (pend_prod != 3'd0) begin
          state_nxt     = MOTOR;
          cnt_nxt       = '0;
          drop_seen_nxt = 1'b0;
        end else if (pend_chg != 3'd0) begin
          state_nxt = CHANGE;
          cnt_nxt   = '0;
        end
      end
      MOTOR: begin
        // A product may fall while the spiral is still turning; remember it
        // so WAIT_DROP completes straight away.
        if (drop_pulse) begin
          drop_seen_nxt = 1'b1;
        end
        if (cnt == MOTOR_LAST) begin
          state_nxt = WAIT_DROP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT_DROP: begin
        if (drop_pulse) begin
          drop_seen_nxt = 1'b1;
        end
        if (drop_seen || drop_pulse) begin
          dec_prod  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          state_nxt = FAULT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      CHANGE: begin
        if (cnt == CHG_LAST) begin
          dec_chg   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      FAULT: begin
        // Acknowledging the fault abandons the item that never dropped.
        if (fault_clr) begin
          dec_prod  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending-request counters. A simultaneous request and completion cancel
  // out, so a full queue that is draining never flags an overflow.
  // --------------------------------------------------------------------------
  logic prod_drop, chg_drop;

  assign prod_drop = prod_req & ~dec_prod & (pend_prod == Q_FULL);
  assign chg_drop  = change_req & ~dec_chg & (pend_chg == Q_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_prod <= 3'd0;
    end else if (prod_req && !dec_prod) begin
      if (pend_prod != Q_FULL) begin
        pend_prod <= pend_prod + 3'd1;
      end
    end else if (!prod_req && dec_prod) begin
      pend_prod <= pend_prod - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_chg <= 3'd0;
    end else if (change_req && !dec_chg) begin
      if (pend_chg != Q_FULL) begin
        pend_chg <= pend_chg + 3'd1;
      end
    end else if (!change_req && dec_chg) begin
      pend_chg <= pend_chg - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (prod_drop || chg_drop) begin
      ovf <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs
  // --------------------------------------------------------------------------
  assign motor_en  = (state == MOTOR);
  assign change_en = (state == CHANGE);
  assign fault     = (state == FAULT);
  assign busy      = (state != IDLE) | (|pend_prod) | (|pend_chg);

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_dispense_ctrl
//  Purpose  : Self-checking bench for vend_dispense_ctrl. A driver applies
//             directed and random stimulus, advances a service-level model
//             and queues the expected outputs; a monitor compares them with
//             the DUT one cycle at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_ctrl;

  localparam int M = 16;
  localparam int C = 4;
  localparam int T = 64;
  localparam int Q = 4;

  logic       clk;
  logic       rst_n;
  logic       prod_req, change_req, drop_sense, fault_clr;
  logic       motor_en, change_en, busy, fault, ovf;
  logic [2:0] pend_prod, pend_chg;

  vend_dispense_ctrl #(
    .MOTOR_CYCLES  (M),
    .CHG_CYCLES    (C),
    .TIMEOUT_CYCLES(T),
    .QDEPTH        (Q)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prod_req  (prod_req),
    .change_req(change_req),
    .drop_sense(drop_sense),
    .fault_clr (fault_clr),
    .motor_en  (motor_en),
    .change_en (change_en),
    .busy      (busy),
    .fault     (fault),
    .ovf       (ovf),
    .pend_prod (pend_prod),
    .pend_chg  (pend_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [10:0] expq[$];

  // Output vector: {motor, change, busy, fault, ovf, pend_prod, pend_chg}
  function automatic logic [10:0] dut_outs();
    return {motor_en, change_en, busy, fault, ovf, pend_prod, pend_chg};
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: which item is being serviced and for how long.
  // --------------------------------------------------------------------------
  localparam int K_NONE = 0, K_PROD = 1, K_CHG = 2, K_FAULT = 3;
  int m_kind, m_el, m_seen, m_pp, m_pc, m_ovf;
  bit d1, d2, d3, d4;   // drop pin as sampled at the last four edges

  task automatic model_reset();
    m_kind = K_NONE; m_el = 0; m_seen = 0;
    m_pp = 0; m_pc = 0; m_ovf = 0;
    d1 = 0; d2 = 0; d3 = 0; d4 = 0;
  endtask

  // The sensor edge becomes visible to the controller three edges later.
  function automatic bit m_pulse();
    return d3 && !d4;
  endfunction

  function automatic bit m_will_finish_prod();
    return (m_kind == K_PROD) && (m_el >= M) && (m_seen != 0 || m_pulse());
  endfunction

  function automatic logic [10:0] m_outs();
    logic mo, ch, bz, fl;
    mo = (m_kind == K_PROD) && (m_el < M);
    ch = (m_kind == K_CHG);
    fl = (m_kind == K_FAULT);
    bz = (m_kind != K_NONE) || (m_pp != 0) || (m_pc != 0);
    return {mo, ch, bz, fl, m_ovf[0], m_pp[2:0], m_pc[2:0]};
  endfunction

  task automatic model_edge(input bit p, input bit c, input bit dp, input bit clr);
    bit pulse = m_pulse();
    bit dec_p = 0;
    bit dec_c = 0;
    case (m_kind)
      K_NONE: begin
        if (m_pp > 0) begin m_kind = K_PROD; m_el = 0; m_seen = 0; end
        else if (m_pc > 0) begin m_kind = K_CHG; m_el = 0; end
      end
      K_PROD: begin
        if (m_el < M) begin
          if (pulse) m_seen = 1;
          m_el++;
        end else if (m_seen != 0 || pulse) begin
          dec_p = 1; m_kind = K_NONE;
        end else if (m_el - M == T - 1) begin
          m_kind = K_FAULT;
        end else begin
          m_el++;
        end
      end
      K_CHG: begin
        if (m_el == C - 1) begin dec_c = 1; m_kind = K_NONE; end
        else m_el++;
      end
      default: begin
        if (clr) begin dec_p = 1; m_kind = K_NONE; end
      end
    endcase
    if (p && !dec_p) begin
      if (m_pp == Q) m_ovf = 1; else m_pp++;
    end else if (!p && dec_p) begin
      m_pp--;
    end
    if (c && !dec_c) begin
      if (m_pc == Q) m_ovf = 1; else m_pc++;
    end else if (!c && dec_c) begin
      m_pc--;
    end
    d4 = d3; d3 = d2; d2 = d1; d1 = dp;
  endtask

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic step(input bit p, input bit c, input bit dp, input bit clr);
    @(negedge clk);
    prod_req = p; change_req = c; drop_sense = dp; fault_clr = clr;
    model_edge(p, c, dp, clr);
    expq.push_back(m_outs());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, (i % 20) < 2, (i % 50) == 49);
    end
  endtask

  task automatic do_reset();
    logic [10:0] got;
    @(negedge clk);
    prod_req = 0; change_req = 0; drop_sense = 0; fault_clr = 0;
    rst_n = 1'b0;
    #1;
    got = dut_outs();
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got %b required %b", got, 11'd0);
    end
    model_reset();
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    model_edge(0, 0, 0, 0);
    expq.push_back(m_outs());
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(posedge clk) begin
    logic [10:0] exp_v, got_v;
    #1;
    cyc++;
    if (rst_n && expq.size() > 0) begin
      exp_v = expq.pop_front();
      got_v = dut_outs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %b required %b (motor,chg,busy,fault,ovf,pp,pc)",
                 cyc, got_v, exp_v);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [10:0] got;
    bit lvl;
    int nres;
    prod_req = 0; change_req = 0; drop_sense = 0; fault_clr = 0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    got = dut_outs();
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got %b required %b", got, 11'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_edge(0, 0, 0, 0);
    expq.push_back(m_outs());

    // Single product with a late drop
    step(1, 0, 0, 0);
    repeat (19) step(0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    repeat (10) step(0, 0, 0, 0);

    // Drop while the motor is still running
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    repeat (20) step(0, 0, 0, 0);

    // Timeout, change request during FAULT, then acknowledge
    step(1, 0, 0, 0);
    repeat (M + T + 2) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (10) step(0, 0, 0, 0);

    // Arbitration order
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    run(60);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    run(150);

    // Overflow, then requests that coincide with a completion at full count
    repeat (5) step(1, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      step(m_will_finish_prod(), 0, (i % 20) < 2, 0);
    end
    run(300);

    // Asynchronous reset while the motor is running
    step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    do_reset();
    repeat (5) step(0, 0, 0, 0);

    // Random traffic
    lvl = 0;
    nres = 0;
    for (int i = 0; i < 3000; i++) begin
      if (lvl) lvl = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
      else     lvl = ($urandom_range(0, 14) == 0);
      if (nres < 3 && m_kind == K_PROD && m_el < M && $urandom_range(0, 40) == 0) begin
        do_reset();
        nres++;
      end else begin
        step($urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0, lvl,
             $urandom_range(0, 19) == 0);
      end
    end

    step(0, 0, 0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
